// File: rtl/serial_rca.sv
// serial_rca: multi-cycle ripple-carry adder/subtractor.
// Processes one DIGIT-bit slice per cycle through a DIGIT-stage ripple chain,
// holding the inter-slice carry in a register. Result after N = WIDTH/DIGIT
// slice cycles, presented with a one-cycle done pulse.
//
// Optional build macro: SERIAL_RCA_FLAGS_EN adds the overflow and zero flags.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start    request, accepted in IDLE or DONE
//   in1/in2  operands A/B, sampled on the accepted start edge
//   cin      carry-in (add mode only)
//   sub      1 = in1 - in2, sampled with start
//   busy     slices in progress
//   done     one-cycle result-valid pulse
//   sum      result, held until the next accepted start
//   carry    final carry-out (subtract: 1 = no borrow)
//   overflow signed overflow (SERIAL_RCA_FLAGS_EN only)
//   zero     sum == 0 (SERIAL_RCA_FLAGS_EN only)
module serial_rca #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_RCA_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("serial_rca: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cr_q, cr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_RCA_FLAGS_EN
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
`endif

  logic [DIGIT-1:0] slice_s;
  logic [DIGIT:0]   chain;
  logic [WIDTH-1:0] sum_shift;

  // DIGIT-stage ripple over the low slice of the operand shift registers
  always_comb begin
    chain    = '0;
    slice_s  = '0;
    chain[0] = cr_q;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      slice_s[i]   = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i+1]   = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // New slice enters at the MSB end; after N shifts the result is aligned
  assign sum_shift = WIDTH'(sum_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cr_d    = cr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_RCA_FLAGS_EN
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_BUSY;
          a_d     = in1;
          // Subtract as A + ~B + 1
          b_d     = sub ? ~in2 : in2;
          cr_d    = sub ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        a_d   = WIDTH'(a_q >> DIGIT);
        b_d   = WIDTH'(b_q >> DIGIT);
        sum_d = sum_shift;
        cr_d  = chain[DIGIT];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          carry_d = chain[DIGIT];
`ifdef SERIAL_RCA_FLAGS_EN
          // Carry into the MSB vs. carry out of it
          ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
          zero_d  = (sum_shift == '0);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_BUSY);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cr_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_RCA_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cr_q    <= cr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_RCA_FLAGS_EN
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;
`ifdef SERIAL_RCA_FLAGS_EN
  assign overflow = ovf_q;
  assign zero     = zero_q;
`endif

endmodule
